mem_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage.
- Consumes the registered ALU result (effective address or computed value), the rt store data and the instruction word.
- Performs LW/LB/LBU/SW/SB against a variable-latency data memory using a req/ack handshake.
- Hands a registered writeback bundle to the writeback stage and stalls upstream while a memory access is outstanding.

---
 rtl/mem_stage_pkg.sv | 34 +++
 rtl/mem_stage_if.sv | 22 ++
 rtl/mem_stage_lane_align.sv | 39 +++
 rtl/mem_stage.sv | 127 ++++++++++++
 tb/tb_mem_stage.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - opcodes, states and byte-enable constants for the memory stage
package mem_stage_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;

    localparam logic [3:0] BE_ALL   = 4'b1111;
    localparam logic [3:0] BE_BYTE0 = 4'b1000;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SB);
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return is_load(op) || is_store(op);
    endfunction

    function automatic logic is_word_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data memory req/ack bus between the memory stage and data memory
interface mem_stage_if #(
    parameter int ADDR_W = 32
) ();
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [3:0]        dmem_be;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lane_align.sv
// rtl/mem_stage_lane_align.sv - big-endian byte-lane placement for stores, extraction/extension for loads
module mem_stage_lane_align
    import mem_stage_pkg::*;
(
    input  logic [5:0]  st_op,
    input  logic [1:0]  st_k,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [5:0]  ld_op,
    input  logic [1:0]  ld_k,
    input  logic [31:0] rdata,
    output logic [31:0] ld_value
);
    logic [7:0] byte_sel;

    always_comb begin
        be    = BE_ALL;
        wdata = st_data;
        if (st_op == OP_SB || st_op == OP_LB || st_op == OP_LBU) begin
            be    = BE_BYTE0 >> st_k;
            wdata = {4{st_data[7:0]}};
        end
    end

    // Offset 0 is the most significant byte of the word
    always_comb begin
        byte_sel = 8'h00;
        case (ld_k)
            2'd0:    byte_sel = rdata[31:24];
            2'd1:    byte_sel = rdata[23:16];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
        ld_value = rdata;
        if (ld_op == OP_LB)       ld_value = {{24{byte_sel[7]}}, byte_sel};
        else if (ld_op == OP_LBU) ld_value = {24'h000000, byte_sel};
    end
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage with variable-latency req/ack data memory and timeout
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ex_valid,
    input  logic [31:0]       ex_insn,
    input  logic [31:0]       ex_alu_out,
    input  logic [31:0]       ex_rt,
    input  logic [4:0]        ex_dest,
    input  logic              ex_reg_we,
    output logic              stall,
    mem_stage_if.master       dmem,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_dest,
    output logic [31:0]       wb_data,
    output logic              mem_err
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       op_q;
    logic [1:0]       k_q;
    logic [4:0]       dest_q;
    logic             reg_we_q;

    logic [5:0]  op;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_value;
    logic        unused_insn;

    assign op          = ex_insn[31:26];
    assign unused_insn = &{1'b0, ex_insn[25:0]};
    assign stall       = (state == ST_ACCESS);

    mem_stage_lane_align u_align (
        .st_op    (op),
        .st_k     (ex_alu_out[1:0]),
        .st_data  (ex_rt),
        .be       (st_be),
        .wdata    (st_wdata),
        .ld_op    (op_q),
        .ld_k     (k_q),
        .rdata    (dmem.dmem_rdata),
        .ld_value (ld_value)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            op_q            <= '0;
            k_q             <= '0;
            dest_q          <= '0;
            reg_we_q        <= 1'b0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            dmem.dmem_be    <= '0;
            wb_valid        <= 1'b0;
            wb_we           <= 1'b0;
            wb_dest         <= '0;
            wb_data         <= '0;
            mem_err         <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            mem_err  <= 1'b0;
            case (state)
                ST_IDLE: if (ex_valid) begin
                    wb_dest <= ex_dest;
                    if (!is_mem_op(op)) begin
                        wb_valid <= 1'b1;
                        wb_we    <= ex_reg_we;
                        wb_data  <= ex_alu_out;
                    end else if (is_word_op(op) && ex_alu_out[1:0] != 2'b00) begin
                        wb_valid <= 1'b1;
                        mem_err  <= 1'b1;
                        wb_data  <= '0;
                    end else begin
                        state           <= ST_ACCESS;
                        cnt             <= '0;
                        op_q            <= op;
                        k_q             <= ex_alu_out[1:0];
                        dest_q          <= ex_dest;
                        reg_we_q        <= ex_reg_we;
                        dmem.dmem_req   <= 1'b1;
                        dmem.dmem_we    <= is_store(op);
                        dmem.dmem_addr  <= {ex_alu_out[ADDR_W-1:2], 2'b00};
                        dmem.dmem_be    <= st_be;
                        dmem.dmem_wdata <= st_wdata;
                    end
                end
                ST_ACCESS: begin
                    // Ack wins over expiry in the same cycle
                    if (dmem.dmem_ack) begin
                        state         <= ST_IDLE;
                        dmem.dmem_req <= 1'b0;
                        wb_valid      <= 1'b1;
                        wb_dest       <= dest_q;
                        wb_we         <= is_load(op_q) & reg_we_q;
                        wb_data       <= is_load(op_q) ? ld_value : 32'h0;
                    end else if (cnt == CNT_LAST) begin
                        state         <= ST_IDLE;
                        dmem.dmem_req <= 1'b0;
                        wb_valid      <= 1'b1;
                        wb_dest       <= dest_q;
                        wb_data       <= '0;
                        mem_err       <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - table-driven self-checking bench for mem_stage
module tb_mem_stage;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_insn = '0;
    logic [31:0] ex_alu_out = '0;
    logic [31:0] ex_rt = '0;
    logic [4:0]  ex_dest = '0;
    logic        ex_reg_we = 1'b0;
    logic        stall;
    logic        wb_valid, wb_we, mem_err;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;

    int checks = 0;
    int failures = 0;

    mem_stage_if #(.ADDR_W(32)) dmem ();

    mem_stage #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ex_valid   (ex_valid),
        .ex_insn    (ex_insn),
        .ex_alu_out (ex_alu_out),
        .ex_rt      (ex_rt),
        .ex_dest    (ex_dest),
        .ex_reg_we  (ex_reg_we),
        .stall      (stall),
        .dmem       (dmem.master),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_dest    (wb_dest),
        .wb_data    (wb_data),
        .mem_err    (mem_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] insn;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [31:0] rdata;
        logic [4:0]  dest;
        logic        we;
        int          ack_after;
        int          req_cycles;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        dwe;
        logic        chk_wdata;
        logic [31:0] wdata;
        logic        wb_we;
        logic        chk_data;
        logic [31:0] wb_data;
        logic        err;
    } vec_t;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    vec_t vecs[11];

    initial begin
        int n;
        dmem.dmem_ack   = 1'b0;
        dmem.dmem_rdata = '0;

        //        insn          alu           rt            rdata         dst we ack req addr          be       dwe cw wdata         wbwe cd wb_data      err
        vecs[0]  = '{32'h0000_0021, 32'h0000_002A, 32'h0,        32'h0,        5'd5, 1'b1, 0, 0, 32'h0,   4'b0000, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_002A, 1'b0};
        vecs[1]  = '{32'h8C00_0000, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 5'd8, 1'b1, 3, 3, 32'h100, 4'b1111, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{32'h8000_0000, 32'h0000_0103, 32'h0,        32'h1122_33F0, 5'd9, 1'b1, 1, 1, 32'h100, 4'b0001, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0};
        vecs[3]  = '{32'h9000_0000, 32'h0000_0103, 32'h0,        32'h1122_33F0, 5'd10, 1'b1, 2, 2, 32'h100, 4'b0001, 1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_00F0, 1'b0};
        vecs[4]  = '{32'hA000_0000, 32'h0000_0101, 32'h0000_00AB, 32'h0,        5'd0, 1'b0, 2, 2, 32'h100, 4'b0100, 1'b1, 1'b1, 32'hABAB_ABAB, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[5]  = '{32'hAC00_0000, 32'h0000_0102, 32'h1234_5678, 32'h0,        5'd0, 1'b0, 0, 0, 32'h0,   4'b0000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1};
        vecs[6]  = '{32'h8C00_0000, 32'h0000_0104, 32'h0,        32'h0,        5'd7, 1'b1, 0, 4, 32'h104, 4'b1111, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1};
        vecs[7]  = '{32'h8000_0000, 32'h0000_0101, 32'h0,        32'h127F_5678, 5'd4, 1'b1, 4, 4, 32'h100, 4'b0100, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_007F, 1'b0};
        vecs[8]  = '{32'hAC00_0000, 32'h0000_0200, 32'hCAFE_F00D, 32'h0,        5'd0, 1'b0, 1, 1, 32'h200, 4'b1111, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[9]  = '{32'h8C00_0000, 32'h0000_0101, 32'h0,        32'h0,        5'd6, 1'b1, 0, 0, 32'h0,   4'b0000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1};
        vecs[10] = '{32'h3400_0000, 32'h0000_1234, 32'h0,        32'h0,        5'd3, 1'b0, 0, 0, 32'h0,   4'b0000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_1234, 1'b0};

        step();
        step();
        check("reset_ctrl", {25'h0, stall, dmem.dmem_req, wb_valid, wb_we, mem_err, 2'b00}, 32'h0);
        check("reset_be_dest", {23'h0, dmem.dmem_be, wb_dest}, 32'h0);
        check("reset_wb_data", wb_data, 32'h0);
        reset_n = 1'b1;
        step();
        check("idle_no_valid", {30'h0, wb_valid, stall}, 32'h0);

        for (int i = 0; i < 11; i++) begin
            ex_insn    = vecs[i].insn;
            ex_alu_out = vecs[i].alu;
            ex_rt      = vecs[i].rt;
            ex_dest    = vecs[i].dest;
            ex_reg_we  = vecs[i].we;
            ex_valid   = 1'b1;
            step();
            ex_valid = 1'b0;
            if (vecs[i].req_cycles > 0) begin
                check($sformatf("v%0d_addr", i), dmem.dmem_addr, vecs[i].addr);
                check($sformatf("v%0d_be", i), {28'h0, dmem.dmem_be}, {28'h0, vecs[i].be});
                check($sformatf("v%0d_dwe", i), {31'h0, dmem.dmem_we}, {31'h0, vecs[i].dwe});
                check($sformatf("v%0d_wb_bubble", i), {31'h0, wb_valid}, 32'h0);
                if (vecs[i].chk_wdata)
                    check($sformatf("v%0d_wdata", i), dmem.dmem_wdata, vecs[i].wdata);
            end
            n = 0;
            while (dmem.dmem_req === 1'b1 && n < 20) begin
                n++;
                check($sformatf("v%0d_stall_c%0d", i, n), {31'h0, stall}, 32'h1);
                if (n == vecs[i].ack_after) begin
                    dmem.dmem_ack   = 1'b1;
                    dmem.dmem_rdata = vecs[i].rdata;
                end
                step();
                dmem.dmem_ack   = 1'b0;
                dmem.dmem_rdata = 32'h0;
            end
            check($sformatf("v%0d_req_cycles", i), n, vecs[i].req_cycles);
            check($sformatf("v%0d_req_stall_low", i), {30'h0, dmem.dmem_req, stall}, 32'h0);
            check($sformatf("v%0d_wb_valid", i), {31'h0, wb_valid}, 32'h1);
            check($sformatf("v%0d_wb_we", i), {31'h0, wb_we}, {31'h0, vecs[i].wb_we});
            check($sformatf("v%0d_mem_err", i), {31'h0, mem_err}, {31'h0, vecs[i].err});
            if (vecs[i].chk_data) begin
                check($sformatf("v%0d_wb_data", i), wb_data, vecs[i].wb_data);
                check($sformatf("v%0d_wb_dest", i), {27'h0, wb_dest}, {27'h0, vecs[i].dest});
            end
            step();
            check($sformatf("v%0d_pulse_end", i), {30'h0, wb_valid, mem_err}, 32'h0);
        end

        ex_insn    = 32'h8C00_0000;
        ex_alu_out = 32'h0000_0300;
        ex_dest    = 5'd2;
        ex_reg_we  = 1'b1;
        ex_valid   = 1'b1;
        step();
        ex_valid = 1'b0;
        check("rst_mid_req_on", {30'h0, dmem.dmem_req, stall}, 32'h3);
        step();
        reset_n = 1'b0;
        step();
        check("rst_mid_cleared", {29'h0, dmem.dmem_req, stall, wb_valid}, 32'h0);
        reset_n = 1'b1;
        step();
        check("rst_mid_no_wb", {29'h0, dmem.dmem_req, stall, wb_valid}, 32'h0);
        step();
        check("rst_mid_no_wb2", {30'h0, wb_valid, mem_err}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
